// File: rtl/dm_mem_pkg.sv
// Shared definitions for the debug-memory access controller: fixed debug
// memory locations, the region enumeration and the address decoder.
package dm_mem_pkg;

    typedef enum logic [2:0] {
        NONE   = 3'd0,
        WHERE  = 3'd1,
        DATA   = 3'd2,
        PROG   = 3'd3,
        ABSCMD = 3'd4,
        FLAGS  = 3'd5
    } dm_region_e;

    // Hart-written status locations and the WhereTo jump slot.
    localparam logic [31:0] HALTED_ADDR    = 32'h0000_0100;
    localparam logic [31:0] GOING_ADDR     = 32'h0000_0108;
    localparam logic [31:0] RESUMING_ADDR  = 32'h0000_0110;
    localparam logic [31:0] EXCEPTION_ADDR = 32'h0000_0118;
    localparam logic [31:0] WHERETO_ADDR   = 32'h0000_0300;

    // Data registers start here; the program buffer sits directly below.
    localparam logic [31:0] DATA_BASE      = 32'h0000_0380;
    localparam logic [31:0] ABSCMD_LO      = 32'h0000_02D8;
    localparam logic [31:0] ABSCMD_HI      = 32'h0000_02FF;
    localparam logic [31:0] FLAGS_LO       = 32'h0000_0400;
    localparam logic [31:0] FLAGS_HI       = 32'h0000_07FF;

    // Classify an already bus-aligned address. The status locations are
    // checked first so they can never alias into a range region.
    function automatic dm_region_e decode_region(
        input logic [31:0] addr,
        input int unsigned data_count,
        input int unsigned progbuf_size
    );
        dm_region_e  region;
        logic [31:0] data_end;
        logic [31:0] prog_start;
        data_end   = DATA_BASE + (data_count * 32'd4);
        prog_start = DATA_BASE - (progbuf_size * 32'd4);
        if ((addr == HALTED_ADDR) || (addr == GOING_ADDR) ||
            (addr == RESUMING_ADDR) || (addr == EXCEPTION_ADDR)) begin
            region = NONE;
        end else if (addr == WHERETO_ADDR) begin
            region = WHERE;
        end else if ((addr >= DATA_BASE) && (addr < data_end)) begin
            region = DATA;
        end else if ((addr >= prog_start) && (addr < DATA_BASE)) begin
            region = PROG;
        end else if ((addr >= ABSCMD_LO) && (addr <= ABSCMD_HI)) begin
            region = ABSCMD;
        end else if ((addr >= FLAGS_LO) && (addr <= FLAGS_HI)) begin
            region = FLAGS;
        end else begin
            region = NONE;
        end
        return region;
    endfunction

endpackage

// File: rtl/dm_mem_ctrl_mh_hart_status.sv
// Per-hart halted / resumeack flags. A Resuming write to a hart beats a
// same-cycle clear of that hart's resumeack; hart ids past NrHarts never
// match any flop and are therefore ignored.
module dm_hart_status_regs #(
    parameter int unsigned NrHarts = 1,
    parameter int unsigned HartIdW = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               set_halted_i,
    input  logic               set_resuming_i,
    input  logic [HartIdW-1:0] hart_id_i,
    input  logic               clear_resumeack_i,
    input  logic [HartIdW-1:0] hartsel_i,
    output logic [NrHarts-1:0] halted_o,
    output logic [NrHarts-1:0] resumeack_o
);

    logic [NrHarts-1:0] halted_r;
    logic [NrHarts-1:0] resumeack_r;
    logic [NrHarts-1:0] halted_s;
    logic [NrHarts-1:0] resumeack_s;
    logic [NrHarts-1:0] halt_hit_s;
    logic [NrHarts-1:0] resume_hit_s;
    logic [NrHarts-1:0] clear_hit_s;

    // Per-hart hit vectors and next-state flags with set-over-clear priority.
    always_comb begin
        halt_hit_s   = {NrHarts{1'b0}};
        resume_hit_s = {NrHarts{1'b0}};
        clear_hit_s  = {NrHarts{1'b0}};
        halted_s     = halted_r;
        resumeack_s  = resumeack_r;
        for (int unsigned i = 0; i < NrHarts; i++) begin
            halt_hit_s[i]   = set_halted_i      & (hart_id_i == HartIdW'(i));
            resume_hit_s[i] = set_resuming_i    & (hart_id_i == HartIdW'(i));
            clear_hit_s[i]  = clear_resumeack_i & (hartsel_i == HartIdW'(i));
            halted_s[i]     = (halted_r[i] | halt_hit_s[i]) & ~resume_hit_s[i];
            resumeack_s[i]  = (resumeack_r[i] & ~clear_hit_s[i]) | resume_hit_s[i];
        end
    end

    // Flag storage, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            halted_r    <= {NrHarts{1'b0}};
            resumeack_r <= {NrHarts{1'b0}};
        end else begin
            halted_r    <= halted_s;
            resumeack_r <= resumeack_s;
        end
    end

    assign halted_o    = halted_r;
    assign resumeack_o = resumeack_r;

endmodule

// File: rtl/dm_mem_ctrl_mh.sv
// Debug-memory access controller: decodes hart-side accesses into regions,
// drives status pulses and data-register write strobes, and answers every
// read one cycle later with its region and an unmapped-address error.
module dm_mem_ctrl_mh
    import dm_mem_pkg::*;
#(
    parameter int unsigned NrHarts        = 1,
    parameter int unsigned DbgAddressBits = 12,
    parameter int unsigned BusWidth       = 32,
    parameter int unsigned DataCount      = 2,
    parameter int unsigned ProgBufSize    = 16,
    localparam int unsigned HartIdW = (NrHarts > 32'd1) ? $clog2(NrHarts) : 32'd1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_i,
    input  logic                        we_i,
    input  logic [DbgAddressBits-1:0]   addr_i,
    input  logic [BusWidth-1:0]         wdata_i,
    input  logic [BusWidth/8-1:0]       be_i,
    input  logic [HartIdW-1:0]          hartsel_i,
    input  logic                        clear_resumeack_i,
    output logic [NrHarts-1:0]          halted_o,
    output logic [NrHarts-1:0]          resumeack_o,
    output logic                        going_o,
    output logic                        exception_o,
    output logic                        data_we_o,
    output logic [$clog2(DataCount):0]  data_idx_o,
    output logic [BusWidth-1:0]         data_wdata_o,
    output logic [BusWidth/8-1:0]       data_be_o,
    output logic                        rvalid_o,
    output logic [2:0]                  rregion_o,
    output logic [DbgAddressBits-1:0]   raddr_o,
    output logic                        rerr_o
);

    localparam int unsigned OffW = $clog2(BusWidth / 8);
    localparam int unsigned IdxW = $clog2(DataCount) + 1;

    logic [DbgAddressBits-1:0] addr_al_s;
    logic [31:0]               addr_ext_s;
    dm_region_e                region_s;
    logic                      wr_s;
    logic                      rd_s;
    logic                      halted_we_s;
    logic                      resuming_we_s;
    logic                      going_we_s;
    logic                      exception_we_s;
    logic                      data_we_s;
    logic [IdxW-1:0]           data_idx_s;

    logic                      going_r;
    logic                      exception_r;
    logic                      data_we_r;
    logic [IdxW-1:0]           data_idx_r;
    logic [BusWidth-1:0]       data_wdata_r;
    logic [BusWidth/8-1:0]     data_be_r;
    logic                      rvalid_r;
    dm_region_e                rregion_r;
    logic [DbgAddressBits-1:0] raddr_r;
    logic                      rerr_r;

    // Decode works on the bus-aligned address; the byte offset only
    // survives in the read-address echo.
    assign addr_al_s  = {addr_i[DbgAddressBits-1:OffW], {OffW{1'b0}}};
    assign addr_ext_s = 32'(addr_al_s);
    assign region_s   = decode_region(addr_ext_s, DataCount, ProgBufSize);

    assign wr_s           = req_i & we_i;
    assign rd_s           = req_i & ~we_i;
    assign halted_we_s    = wr_s & (addr_ext_s == HALTED_ADDR);
    assign resuming_we_s  = wr_s & (addr_ext_s == RESUMING_ADDR);
    assign going_we_s     = wr_s & (addr_ext_s == GOING_ADDR);
    assign exception_we_s = wr_s & (addr_ext_s == EXCEPTION_ADDR);
    assign data_we_s      = wr_s & (region_s == DATA);
    // 32-bit word index; a 64-bit access covers idx and idx+1.
    assign data_idx_s     = IdxW'((addr_ext_s - DATA_BASE) >> 2'd2);

    dm_hart_status_regs #(
        .NrHarts (NrHarts),
        .HartIdW (HartIdW)
    ) u_hart_status (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .set_halted_i      (halted_we_s),
        .set_resuming_i    (resuming_we_s),
        .hart_id_i         (wdata_i[HartIdW-1:0]),
        .clear_resumeack_i (clear_resumeack_i),
        .hartsel_i         (hartsel_i),
        .halted_o          (halted_o),
        .resumeack_o       (resumeack_o)
    );

    // Response, pulse and data-strobe registers; payloads load only when used.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            going_r      <= 1'b0;
            exception_r  <= 1'b0;
            data_we_r    <= 1'b0;
            data_idx_r   <= {IdxW{1'b0}};
            data_wdata_r <= {BusWidth{1'b0}};
            data_be_r    <= {(BusWidth/8){1'b0}};
            rvalid_r     <= 1'b0;
            rregion_r    <= NONE;
            raddr_r      <= {DbgAddressBits{1'b0}};
            rerr_r       <= 1'b0;
        end else begin
            going_r     <= going_we_s;
            exception_r <= exception_we_s;
            data_we_r   <= data_we_s;
            rvalid_r    <= rd_s;
            if (data_we_s) begin
                data_idx_r   <= data_idx_s;
                data_wdata_r <= wdata_i;
                data_be_r    <= be_i;
            end
            if (rd_s) begin
                rregion_r <= region_s;
                raddr_r   <= addr_i;
                rerr_r    <= (region_s == NONE);
            end
        end
    end

    assign going_o      = going_r;
    assign exception_o  = exception_r;
    assign data_we_o    = data_we_r;
    assign data_idx_o   = data_idx_r;
    assign data_wdata_o = data_wdata_r;
    assign data_be_o    = data_be_r;
    assign rvalid_o     = rvalid_r;
    assign rregion_o    = rregion_r;
    assign raddr_o      = raddr_r;
    assign rerr_o       = rerr_r;

endmodule

// File: tb/tb_dm_mem_ctrl_mh.sv
// Scoreboard bench for dm_mem_ctrl_mh: stimulus pushes expected per-cycle
// responses computed by an address-map reference model; a negedge monitor
// pops and compares them against the DUT outputs.
module tb_dm_mem_ctrl_mh;
    import dm_mem_pkg::*;

    localparam int NR_HARTS = 3;
    localparam int HID_W    = 2;
    localparam int AW       = 12;
    localparam int BW       = 64;
    localparam int BE_W     = 8;
    localparam int DATA_CNT = 4;
    localparam int PB_SIZE  = 16;
    localparam int IDX_W    = 3;

    localparam int K_NONE = 0;
    localparam int K_READ = 1;
    localparam int K_DATA = 2;
    localparam int K_GO   = 3;
    localparam int K_EXC  = 4;

    logic                clk = 1'b0;
    logic                rst_ni;
    logic                req;
    logic                we;
    logic [AW-1:0]       addr;
    logic [BW-1:0]       wdata;
    logic [BE_W-1:0]     be;
    logic [HID_W-1:0]    hartsel;
    logic                clr_ra;
    logic [NR_HARTS-1:0] halted_o;
    logic [NR_HARTS-1:0] resumeack_o;
    logic                going_o;
    logic                exception_o;
    logic                data_we_o;
    logic [IDX_W-1:0]    data_idx_o;
    logic [BW-1:0]       data_wdata_o;
    logic [BE_W-1:0]     data_be_o;
    logic                rvalid_o;
    logic [2:0]          rregion_o;
    logic [AW-1:0]       raddr_o;
    logic                rerr_o;

    dm_mem_ctrl_mh #(
        .NrHarts        (NR_HARTS),
        .DbgAddressBits (AW),
        .BusWidth       (BW),
        .DataCount      (DATA_CNT),
        .ProgBufSize    (PB_SIZE)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .req_i             (req),
        .we_i              (we),
        .addr_i            (addr),
        .wdata_i           (wdata),
        .be_i              (be),
        .hartsel_i         (hartsel),
        .clear_resumeack_i (clr_ra),
        .halted_o          (halted_o),
        .resumeack_o       (resumeack_o),
        .going_o           (going_o),
        .exception_o       (exception_o),
        .data_we_o         (data_we_o),
        .data_idx_o        (data_idx_o),
        .data_wdata_o      (data_wdata_o),
        .data_be_o         (data_be_o),
        .rvalid_o          (rvalid_o),
        .rregion_o         (rregion_o),
        .raddr_o           (raddr_o),
        .rerr_o            (rerr_o)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int            due;
        int            kind;
        dm_region_e    rg;
        logic [AW-1:0] raddr;
        logic          err;
        logic [IDX_W-1:0] idx;
        logic [BW-1:0] wdata;
        logic [BE_W-1:0] be;
        logic [NR_HARTS-1:0] halted;
        logic [NR_HARTS-1:0] rack;
    } exp_t;

    exp_t exp_q[$];
    bit [NR_HARTS-1:0] halted_m;
    bit [NR_HARTS-1:0] rack_m;
    int n_vec  = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Debug memory map as a priority-ordered table of [lo, hi] windows.
    function automatic dm_region_e ref_region(input int a);
        int lo_t[9];
        int hi_t[9];
        dm_region_e rg_t[9];
        lo_t = '{'h100, 'h108, 'h110, 'h118, 'h300, 'h380, 'h380 - 4*PB_SIZE, 'h2D8, 'h400};
        hi_t = '{'h100, 'h108, 'h110, 'h118, 'h300, 'h380 + 4*DATA_CNT - 1, 'h37F, 'h2FF, 'h7FF};
        rg_t = '{NONE, NONE, NONE, NONE, WHERE, DATA, PROG, ABSCMD, FLAGS};
        for (int k = 0; k < 9; k++) begin
            if (a >= lo_t[k] && a <= hi_t[k]) return rg_t[k];
        end
        return NONE;
    endfunction

    // Drive one cycle of stimulus, update the model and queue the expectation.
    task automatic step(input logic rq, input logic w, input logic [AW-1:0] a,
                        input logic [BW-1:0] wd, input logic [BE_W-1:0] b,
                        input logic [HID_W-1:0] hs, input logic clr);
        exp_t e;
        int al;
        int id;
        int sel;
        req = rq; we = w; addr = a; wdata = wd; be = b; hartsel = hs; clr_ra = clr;
        n_vec++;
        al  = int'(a) & ~(BE_W - 1);
        id  = int'(wd[HID_W-1:0]);
        sel = int'(hs);
        e.due = edge_n + 1; e.kind = K_NONE; e.rg = NONE; e.raddr = '0; e.err = 1'b0;
        e.idx = '0; e.wdata = '0; e.be = '0;
        // clear first, so a same-cycle Resuming write to the same hart wins
        if (clr && sel < NR_HARTS) rack_m[sel] = 1'b0;
        if (rq && !w) begin
            e.kind  = K_READ;
            e.rg    = ref_region(al);
            e.raddr = a;
            e.err   = (e.rg == NONE);
        end else if (rq && w) begin
            if (al == 'h108) e.kind = K_GO;
            else if (al == 'h118) e.kind = K_EXC;
            else if (al == 'h100) begin
                if (id < NR_HARTS) halted_m[id] = 1'b1;
            end else if (al == 'h110) begin
                if (id < NR_HARTS) begin
                    halted_m[id] = 1'b0;
                    rack_m[id]   = 1'b1;
                end
            end else if (ref_region(al) == DATA) begin
                e.kind  = K_DATA;
                e.idx   = IDX_W'((al - 'h380) / 4);
                e.wdata = wd;
                e.be    = b;
            end
        end
        e.halted = halted_m;
        e.rack   = rack_m;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare each cycle's outputs against the queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   dk;
        int   nev;
        if (rst_ni) begin
            nev = int'(rvalid_o) + int'(data_we_o) + int'(going_o) + int'(exception_o);
            dk  = rvalid_o ? K_READ : data_we_o ? K_DATA : going_o ? K_GO :
                  exception_o ? K_EXC : K_NONE;
            if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
                e = exp_q.pop_front();
                chk("event_count", nev, (e.kind == K_NONE) ? 0 : 1);
                chk("event_kind", dk, e.kind);
                if (e.kind == K_READ) begin
                    chk("rregion", rregion_o, e.rg);
                    chk("raddr", raddr_o, e.raddr);
                    chk("rerr", rerr_o, e.err);
                end
                if (e.kind == K_DATA) begin
                    chk("data_idx", data_idx_o, e.idx);
                    chk("data_wdata", data_wdata_o, e.wdata);
                    chk("data_be", data_be_o, e.be);
                end
                chk("halted", halted_o, e.halted);
                chk("resumeack", resumeack_o, e.rack);
            end else begin
                chk("idle_events", nev, 0);
            end
        end
    end

    logic [AW-1:0] pool [16] = '{12'h100, 12'h108, 12'h110, 12'h118, 12'h300, 12'h380,
                                 12'h388, 12'h390, 12'h340, 12'h378, 12'h338, 12'h2D8,
                                 12'h2F8, 12'h2D0, 12'h400, 12'h7F8};

    task automatic random_cycles(input int n);
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = pool[$urandom_range(0, 15)];
                if ($urandom_range(0, 3) == 0) a = a + AW'($urandom_range(0, 7));
            end else begin
                a = AW'($urandom_range(0, 4095));
            end
            step(($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)), a,
                 {$urandom, $urandom}, BE_W'($urandom), HID_W'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        logic [2:0] rd_exp [6];
        logic [AW-1:0] rd_addr [6];
        rst_ni = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        hartsel = '0; clr_ra = 1'b0;
        halted_m = '0; rack_m = '0;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;

        chk("rst_halted", halted_o, 0);
        chk("rst_resumeack", resumeack_o, 0);
        chk("rst_going", going_o, 0);
        chk("rst_exception", exception_o, 0);
        chk("rst_data_we", data_we_o, 0);
        chk("rst_data_idx", data_idx_o, 0);
        chk("rst_data_wdata", data_wdata_o, 0);
        chk("rst_data_be", data_be_o, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_rerr", rerr_o, 0);
        chk("rst_raddr", raddr_o, 0);
        chk("rst_rregion", rregion_o, NONE);

        // Halted write for hart 0, then read back of the status location.
        step(1'b1, 1'b1, 12'h100, 64'd0, 8'hFF, 2'd0, 1'b0);
        chk("halted_hart0", halted_o, 3'b001);
        step(1'b1, 1'b0, 12'h100, 64'd0, 8'h00, 2'd0, 1'b0);
        chk("read_status_rvalid", rvalid_o, 1);
        chk("read_status_rerr", rerr_o, 1);

        // Resuming and clear on the same hart: set wins; then clear alone.
        step(1'b1, 1'b1, 12'h110, 64'd2, 8'hFF, 2'd2, 1'b1);
        chk("resume_set_wins", resumeack_o, 3'b100);
        step(1'b0, 1'b0, 12'h000, 64'd0, 8'h00, 2'd2, 1'b1);
        chk("clear_alone", resumeack_o, 3'b000);

        // Back-to-back reads across every region.
        rd_addr = '{12'h300, 12'h384, 12'h340, 12'h2D8, 12'h400, 12'h200};
        rd_exp  = '{WHERE, DATA, PROG, ABSCMD, FLAGS, NONE};
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, rd_addr[k], 64'd0, 8'h00, 2'd0, 1'b0);
            chk("seq_rvalid", rvalid_o, 1);
            chk("seq_rregion", rregion_o, rd_exp[k]);
            chk("seq_rerr", rerr_o, (k == 5) ? 1 : 0);
        end

        // Data window edges with a 64-bit bus and four data words.
        step(1'b1, 1'b1, 12'h388, 64'hDEAD_BEEF_0123_4567, 8'hFF, 2'd0, 1'b0);
        chk("data_strobe", data_we_o, 1);
        chk("data_idx2", data_idx_o, 2);
        step(1'b1, 1'b1, 12'h390, 64'h1, 8'hFF, 2'd0, 1'b0);
        chk("data_past_end", data_we_o, 0);

        // Going then Exception pulses, then an out-of-range hart id.
        step(1'b1, 1'b1, 12'h108, 64'd0, 8'hFF, 2'd0, 1'b0);
        chk("going_pulse", going_o, 1);
        step(1'b1, 1'b1, 12'h118, 64'd0, 8'hFF, 2'd0, 1'b0);
        chk("going_drop", going_o, 0);
        chk("exception_pulse", exception_o, 1);
        step(1'b1, 1'b1, 12'h100, 64'd3, 8'hFF, 2'd0, 1'b0);
        chk("exception_drop", exception_o, 0);
        chk("bad_hart_ignored", halted_o, 3'b001);

        random_cycles(400);

        // Reset arriving while a read response is being presented.
        step(1'b1, 1'b1, 12'h100, 64'd1, 8'hFF, 2'd0, 1'b0);
        step(1'b1, 1'b0, 12'h380, 64'd0, 8'h00, 2'd0, 1'b0);
        chk("pre_reset_rvalid", rvalid_o, 1);
        chk("pre_reset_halted1", halted_o[1], 1);
        req = 1'b0; clr_ra = 1'b0;
        rst_ni = 1'b0;
        exp_q.delete();
        halted_m = '0; rack_m = '0;
        #1;
        chk("mid_reset_rvalid", rvalid_o, 0);
        chk("mid_reset_halted", halted_o, 0);
        chk("mid_reset_resumeack", resumeack_o, 0);
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;

        random_cycles(100);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 12'h000, 64'd0, 8'h00, 2'd0, 1'b0);
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
